// File: rtl/i2c_slv_regif_pkg.sv
// Shared types and constants for the I2C register-file target: FSM states,
// ACK/NACK bus levels and the SCL-low timeout counter type.
package i2c_slv_regif_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_DEVA = 4'd1,
    ST_DACK = 4'd2,
    ST_REGA = 4'd3,
    ST_RACK = 4'd4,
    ST_WDAT = 4'd5,
    ST_WACK = 4'd6,
    ST_RDAT = 4'd7,
    ST_MACK = 4'd8,
    ST_IGNR = 4'd9
  } state_e;

  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  localparam int TMO_W = 16;
  typedef logic [TMO_W-1:0] tmo_t;

endpackage

// File: rtl/i2c_deglitch.sv
// Two-flop synchroniser followed by a glitch filter: the output follows the
// pad only after the new level has been stable for FILT_LEN clk cycles.
module i2c_deglitch #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic srstz,
  input  logic i_pad,
  output logic o_filt
);

  localparam logic [2:0] CNT_LAST = 3'(FILT_LEN - 1);

  logic [1:0] sync_q;
  logic [2:0] cnt_q;
  logic       filt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!srstz) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], i_pad};
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  assign o_filt = filt_q;

endmodule

// File: rtl/i2c_slv_regif.sv
// I2C target bridging SCL/SDA to single-cycle register write/read strobes.
// Optional SCL-stuck-low recovery is built when I2C_SCL_TIMEOUT_EN is defined.
module i2c_slv_regif
  import i2c_slv_regif_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h70,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       srstz,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_addr,
  output logic [7:0] o_wdat,
  output logic       o_wr,
  output logic       o_rd,
  input  logic [7:0] i_rdat,
  output logic       o_busy
);

  logic scl_f, sda_f, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det, tmo_hit;

  i2c_deglitch #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .srstz(srstz), .i_pad(i_scl), .o_filt(scl_f)
  );
  i2c_deglitch #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .srstz(srstz), .i_pad(i_sda), .o_filt(sda_f)
  );

  assign scl_rise  =  scl_f & ~scl_q;
  assign scl_fall  = ~scl_f &  scl_q;
  assign start_det =  scl_f &  scl_q &  sda_q & ~sda_f;
  assign stop_det  =  scl_f &  scl_q & ~sda_q &  sda_f;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, addr_q, addr_d, wdat_q, wdat_d;
  logic       wr_q, wr_d, rd_q, rd_d, oe_q, oe_d, busy_q, busy_d, rw_q, rw_d;
  logic [7:0] byte_in;
  logic       last_bit;

  assign byte_in  = {shift_q[6:0], sda_f};
  assign last_bit = (cnt_q == 3'd7);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    oe_d    = oe_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    if (rd_q) shift_d = i_rdat;

    if (stop_det || tmo_hit) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (start_det) begin
      state_d = ST_DEVA;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_DEVA, ST_REGA, ST_WDAT: begin
          if (scl_fall) oe_d = 1'b0;
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (last_bit && state_q == ST_DEVA) begin
              rw_d    = byte_in[0];
              state_d = (byte_in[7:1] == DEV_ADDR) ? ST_DACK : ST_IGNR;
            end else if (last_bit && state_q == ST_REGA) begin
              addr_d  = byte_in;
              state_d = ST_RACK;
            end else if (last_bit) begin
              wdat_d  = byte_in;
              wr_d    = 1'b1;
              state_d = ST_WACK;
            end
          end
        end
        // cnt_q[0] marks that the ACK bit's SCL-rise has already passed.
        ST_DACK, ST_RACK, ST_WACK: begin
          if (scl_fall && !cnt_q[0]) begin
            oe_d = ~SDA_ACK;
          end else if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = (state_q == ST_DACK) ? ST_REGA : ST_WDAT;
            if (state_q == ST_WACK) addr_d = addr_q + 8'd1;
          end
          if (scl_rise && state_q == ST_DACK && rw_q) begin
            rd_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_RDAT;
          end else if (scl_rise) begin
            cnt_d = 3'd1;
          end
        end
        ST_RDAT: begin
          if (scl_fall) oe_d = ~shift_q[7];
          if (scl_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (last_bit) state_d = ST_MACK;
          end
        end
        ST_MACK: begin
          if (scl_fall) oe_d = 1'b0;
          if (scl_rise && sda_f == SDA_NACK) begin
            state_d = ST_IGNR;
          end else if (scl_rise) begin
            addr_d  = addr_q + 8'd1;
            rd_d    = 1'b1;
            state_d = ST_RDAT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!srstz) begin
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      scl_q   <= scl_f;
      sda_q   <= sda_f;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
    end
  end

`ifdef I2C_SCL_TIMEOUT_EN
  tmo_t tmo_q, tmo_d;

  assign tmo_hit = &tmo_q;

  always_comb begin
    tmo_d = tmo_q;
    if (scl_rise || !busy_q || tmo_hit) tmo_d = '0;
    else if (!scl_f)                    tmo_d = tmo_q + tmo_t'(1);
  end

  always_ff @(posedge clk) begin
    if (!srstz) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign o_sda_oe = oe_q;
  assign o_addr   = addr_q;
  assign o_wdat   = wdat_q;
  assign o_wr     = wr_q;
  assign o_rd     = rd_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_i2c_slv_regif.sv
// Bench for i2c_slv_regif: a bit-banged I2C master plus a transaction-level
// model of the expected register writes, reads and final address.
module tb_i2c_slv_regif;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk, srstz, scl_m, sda_m;
  logic       o_sda_oe, o_wr, o_rd, o_busy;
  logic [7:0] o_addr, o_wdat, i_rdat;
  logic       sda_line;

  logic [7:0]  rf [256];
  logic [7:0]  tx_buf [8];
  logic [7:0]  rx_buf [8];
  logic [15:0] wr_log [$];
  logic [7:0]  rd_log [$];
  logic        oe_seen, both_seen;
  int          n_total, n_pass;

  assign sda_line = sda_m & ~o_sda_oe;
  assign i_rdat   = rf[o_addr];

  i2c_slv_regif #(.DEV_ADDR(7'h70), .FILT_LEN(3)) dut (
    .clk(clk), .srstz(srstz), .i_scl(scl_m), .i_sda(sda_line),
    .o_sda_oe(o_sda_oe), .o_addr(o_addr), .o_wdat(o_wdat), .o_wr(o_wr),
    .o_rd(o_rd), .i_rdat(i_rdat), .o_busy(o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (o_wr) wr_log.push_back({o_addr, o_wdat});
    if (o_rd) rd_log.push_back(o_addr);
    if (o_sda_oe) oe_seen = 1'b1;
    if (o_wr && o_rd) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    n_total++;
    assert (obs === expected) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expected);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    sda_m = b;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(Q);
    r = sda_line;
    wait_clks(Q);
    scl_m = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(Q);
    sda_m = 1'b0;
    wait_clks(Q);
    scl_m = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(Q);
    sda_m = 1'b1;
    wait_clks(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], dummy);
    xfer_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic dummy;
    for (int i = 7; i >= 0; i--) xfer_bit(1'b1, d[i]);
    xfer_bit(mack, dummy);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    oe_seen = 1'b0;
  endtask

  // Write burst of n bytes from tx_buf, then check the strobes it produced.
  task automatic do_write(input string tag, input logic [7:0] reg_a, input int n);
    logic       ack;
    logic [7:0] a;
    clear_logs();
    i2c_start();
    write_byte(8'hE0, ack);
    check($sformatf("%s_dev_ack", tag), ack, 0);
    write_byte(reg_a, ack);
    check($sformatf("%s_reg_ack", tag), ack, 0);
    check($sformatf("%s_busy", tag), o_busy, 1);
    for (int i = 0; i < n; i++) begin
      write_byte(tx_buf[i], ack);
      check($sformatf("%s_dat_ack%0d", tag, i), ack, 0);
    end
    i2c_stop();
    check($sformatf("%s_idle", tag), o_busy, 0);
    check($sformatf("%s_nwr", tag), wr_log.size(), n);
    check($sformatf("%s_nrd", tag), rd_log.size(), 0);
    for (int i = 0; i < n; i++) begin
      a = reg_a + 8'(i);
      check($sformatf("%s_wr%0d", tag, i), wr_log[i], {a, tx_buf[i]});
    end
    a = reg_a + 8'(n);
    check($sformatf("%s_addr", tag), o_addr, a);
  endtask

  // Set register pointer, repeated START, read n bytes (ACK all but last).
  task automatic do_read(input string tag, input logic [7:0] reg_a, input int n);
    logic       ack;
    logic [7:0] a;
    clear_logs();
    i2c_start();
    write_byte(8'hE0, ack);
    check($sformatf("%s_dev_ack", tag), ack, 0);
    write_byte(reg_a, ack);
    check($sformatf("%s_reg_ack", tag), ack, 0);
    i2c_start();
    write_byte(8'hE1, ack);
    check($sformatf("%s_rdev_ack", tag), ack, 0);
    for (int i = 0; i < n; i++) read_byte(i == n - 1, rx_buf[i]);
    check($sformatf("%s_released", tag), o_sda_oe, 0);
    i2c_stop();
    check($sformatf("%s_idle", tag), o_busy, 0);
    check($sformatf("%s_nrd", tag), rd_log.size(), n);
    check($sformatf("%s_nwr", tag), wr_log.size(), 0);
    for (int i = 0; i < n; i++) begin
      a = reg_a + 8'(i);
      check($sformatf("%s_rdaddr%0d", tag, i), rd_log[i], a);
      check($sformatf("%s_rddat%0d", tag, i), rx_buf[i], rf[a]);
    end
    a = reg_a + 8'(n - 1);
    check($sformatf("%s_addr", tag), o_addr, a);
  endtask

  initial begin
    logic       ack, dummy;
    logic [7:0] reg_a;
    int         n;
    n_total   = 0;
    n_pass    = 0;
    both_seen = 1'b0;
    oe_seen   = 1'b0;
    srstz     = 1'b0;
    scl_m     = 1'b1;
    sda_m     = 1'b1;
    for (int i = 0; i < 256; i++) rf[i] = 8'($urandom);
    rf[8'h20] = 8'h3C;
    rf[8'h21] = 8'hC3;
    rf[8'h40] = 8'h15;

    wait_clks(4);
    check("rst_oe",   o_sda_oe, 0);
    check("rst_addr", o_addr,   0);
    check("rst_wdat", o_wdat,   0);
    check("rst_wr",   o_wr,     0);
    check("rst_rd",   o_rd,     0);
    check("rst_busy", o_busy,   0);
    srstz = 1'b1;
    wait_clks(10);

    tx_buf[0] = 8'hA5;
    tx_buf[1] = 8'h5A;
    do_write("burst", 8'h10, 2);

    do_read("rd", 8'h20, 2);
    check("rd_byte0", rx_buf[0], 8'h3C);
    check("rd_byte1", rx_buf[1], 8'hC3);

    clear_logs();
    i2c_start();
    write_byte(8'hE2, ack);
    check("wa_dev_nack", ack, 1);
    check("wa_busy", o_busy, 1);
    write_byte(8'h10, ack);
    check("wa_reg_nack", ack, 1);
    write_byte(8'hFF, ack);
    check("wa_dat_nack", ack, 1);
    i2c_stop();
    check("wa_oe_never", oe_seen, 0);
    check("wa_nwr", wr_log.size(), 0);
    check("wa_nrd", rd_log.size(), 0);
    check("wa_addr", o_addr, 8'h21);

    clear_logs();
    i2c_start();
    write_byte(8'hE0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    for (int i = 0; i < 4; i++) xfer_bit(1'($urandom), dummy);
    i2c_stop();
    check("wrap_nwr", wr_log.size(), 2);
    check("wrap_wr0", wr_log[0], 16'hFF11);
    check("wrap_wr1", wr_log[1], 16'h0022);
    check("wrap_addr", o_addr, 8'h01);

    @(negedge clk) sda_m = 1'b0;
    @(negedge clk) sda_m = 1'b1;
    wait_clks(Q);
    check("glitch_no_start", o_busy, 0);
    i2c_start();
    write_byte(8'hE0, ack);
    sda_m = 1'b0;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(Q);
    @(negedge clk) sda_m = 1'b1;
    @(negedge clk) sda_m = 1'b0;
    wait_clks(Q);
    check("glitch_no_stop", o_busy, 1);
    scl_m = 1'b0;
    wait_clks(Q);
    i2c_stop();
    check("glitch_stop", o_busy, 0);

    clear_logs();
    i2c_start();
    write_byte(8'hE0, ack);
    write_byte(8'h40, ack);
    i2c_start();
    write_byte(8'hE1, ack);
    check("rst_mid_driving", o_sda_oe, 1);
    srstz = 1'b0;
    @(negedge clk);
    check("rst_mid_release", o_sda_oe, 0);
    check("rst_mid_busy", o_busy, 0);
    srstz = 1'b1;
    sda_m = 1'b1;
    scl_m = 1'b1;
    wait_clks(2 * Q);
    i2c_start();
    write_byte(8'hE0, ack);
    check("rst_recover_ack", ack, 0);
    i2c_stop();
    check("rst_recover_addr", o_addr, 0);

    for (int t = 0; t < 6; t++) begin
      reg_a = 8'($urandom);
      n     = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) do_write($sformatf("rw%0d", t), reg_a, n);
      else                           do_read($sformatf("rr%0d", t), reg_a, n);
    end

    check("never_wr_and_rd", both_seen, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
